// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS main controller.
package mips_ctrl_pkg;

  // Controller states; the numeric codes are visible on state_o for debug.
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11,
    S_ORIEX   = 4'd12
  } state_t;

  // Opcode field values.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // aluop values handed to the ALU decoder.
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  // ALU B operand selects.
  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // Next-PC selects.
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Full control word driven into the datapath.
  typedef struct packed {
    logic       pcwrite;
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zeroext;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

  // State that follows DECODE for an opcode. Every legal opcode leaves
  // DECODE for a non-FETCH state, so S_FETCH doubles as the illegal marker.
  function automatic state_t decode_next(input logic [5:0] op,
                                         input logic       bne_en,
                                         input logic       ori_en);
    state_t s;
    s = S_FETCH;
    case (op)
      OP_LW, OP_SW: s = S_MEMADR;
      OP_RTYPE:     s = S_EXECUTE;
      OP_BEQ:       s = S_BRANCH;
      OP_BNE:       if (bne_en) s = S_BRANCH;
      OP_ADDI:      s = S_ADDIEX;
      OP_ORI:       if (ori_en) s = S_ORIEX;
      OP_J:         s = S_JUMP;
      default:      s = S_FETCH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational state-to-control-word decoder (Moore outputs, plus the
// branch condition and the fetch handshake).
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
#(
  parameter logic SUPPORT_BNE = 1'b1
) (
  input  state_t     state,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  // Control word per state; anything not assigned stays 0.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.iord    = 1'b0;
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.aluop   = ALU_ADD;
        ctrl.pcsrc   = PCSRC_ALU;
        ctrl.irwrite = mem_ready;
        ctrl.pcwrite = mem_ready;
      end
      S_DECODE: begin
        ctrl.alusrcb = SRCB_IMMSH;
        ctrl.aluop   = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.iord = 1'b1;
      end
      S_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_MEMWR: begin
        // Strobe stays up for every wait cycle including the ready one.
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_RT;
        ctrl.aluop   = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_RT;
        ctrl.aluop   = ALU_SUB;
        ctrl.pcsrc   = PCSRC_ALUOUT;
        ctrl.pcwrite = (SUPPORT_BNE && (op == OP_BNE)) ? ~zero : zero;
      end
      S_ORIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALU_OR;
        ctrl.zeroext = 1'b1;
      end
      S_IMMWB: begin
        ctrl.regwrite = 1'b1;
      end
      S_JUMP: begin
        ctrl.pcsrc   = PCSRC_JUMP;
        ctrl.pcwrite = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main controller: state register, next-state logic,
// memory handshake and reset gating of all write strobes.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter logic SUPPORT_BNE   = 1'b1,
  parameter logic SUPPORT_ORI   = 1'b1,
  parameter logic MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       zeroext,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  state_t state_reg;
  state_t state_next;
  state_t decode_state;
  ctrl_t  ctrl;
  logic   ready_eff;

  // Without a handshake the memory is assumed to complete every access at once.
  assign ready_eff    = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign decode_state = decode_next(op, SUPPORT_BNE, SUPPORT_ORI);

  // State register with synchronous reset to FETCH.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_FETCH;
    else       state_reg <= state_next;
  end

  // Next-state sequencing; unused codes fall back to FETCH.
  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:            state_next = ready_eff ? S_DECODE : S_FETCH;
      S_DECODE:           state_next = decode_state;
      S_MEMADR:           state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:            state_next = ready_eff ? S_MEMWB : S_MEMRD;
      S_MEMWR:            state_next = ready_eff ? S_FETCH : S_MEMWR;
      S_EXECUTE:          state_next = S_ALUWB;
      S_ADDIEX, S_ORIEX:  state_next = S_IMMWB;
      default:            state_next = S_FETCH;
    endcase
  end

  mips_ctrl_outdec #(
    .SUPPORT_BNE (SUPPORT_BNE)
  ) u_outdec (
    .state     (state_reg),
    .op        (op),
    .zero      (zero),
    .mem_ready (ready_eff),
    .ctrl      (ctrl)
  );

  // Write strobes and the illegal flag are suppressed while reset is held,
  // so an abandoned instruction never leaves a partial write behind.
  assign pcwrite    = ctrl.pcwrite  & ~reset;
  assign irwrite    = ctrl.irwrite  & ~reset;
  assign memwrite   = ctrl.memwrite & ~reset;
  assign regwrite   = ctrl.regwrite & ~reset;
  assign illegal_op = (state_reg == S_DECODE) && (decode_state == S_FETCH) && !reset;

  assign iord     = ctrl.iord;
  assign regdst   = ctrl.regdst;
  assign memtoreg = ctrl.memtoreg;
  assign alusrca  = ctrl.alusrca;
  assign alusrcb  = ctrl.alusrcb;
  assign zeroext  = ctrl.zeroext;
  assign pcsrc    = ctrl.pcsrc;
  assign aluop    = ctrl.aluop;
  assign state_o  = state_reg;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: one instance with all options on,
// one with bne/ori/handshake disabled.
module tb_mips_multicycle_ctrl;

  logic clk;
  int   vectors;
  int   miscompares;

  // Instance a: default parameters
  logic       reset_a, zero_a, mem_ready_a;
  logic [5:0] op_a;
  logic       a_pcwrite, a_iord, a_irwrite, a_memwrite, a_regdst, a_memtoreg;
  logic       a_regwrite, a_alusrca, a_zeroext, a_illegal;
  logic [1:0] a_alusrcb, a_pcsrc, a_aluop;
  logic [3:0] a_state;

  // Instance b: SUPPORT_BNE=0, SUPPORT_ORI=0, MEM_HANDSHAKE=0
  logic       reset_b, zero_b, mem_ready_b;
  logic [5:0] op_b;
  logic       b_pcwrite, b_iord, b_irwrite, b_memwrite, b_regdst, b_memtoreg;
  logic       b_regwrite, b_alusrca, b_zeroext, b_illegal;
  logic [1:0] b_alusrcb, b_pcsrc, b_aluop;
  logic [3:0] b_state;

  mips_multicycle_ctrl dut_a (
    .clk(clk), .reset(reset_a), .op(op_a), .zero(zero_a), .mem_ready(mem_ready_a),
    .pcwrite(a_pcwrite), .iord(a_iord), .irwrite(a_irwrite), .memwrite(a_memwrite),
    .regdst(a_regdst), .memtoreg(a_memtoreg), .regwrite(a_regwrite),
    .alusrca(a_alusrca), .alusrcb(a_alusrcb), .zeroext(a_zeroext), .pcsrc(a_pcsrc),
    .aluop(a_aluop), .illegal_op(a_illegal), .state_o(a_state)
  );

  mips_multicycle_ctrl #(
    .SUPPORT_BNE(1'b0), .SUPPORT_ORI(1'b0), .MEM_HANDSHAKE(1'b0)
  ) dut_b (
    .clk(clk), .reset(reset_b), .op(op_b), .zero(zero_b), .mem_ready(mem_ready_b),
    .pcwrite(b_pcwrite), .iord(b_iord), .irwrite(b_irwrite), .memwrite(b_memwrite),
    .regdst(b_regdst), .memtoreg(b_memtoreg), .regwrite(b_regwrite),
    .alusrca(b_alusrca), .alusrcb(b_alusrcb), .zeroext(b_zeroext), .pcsrc(b_pcsrc),
    .aluop(b_aluop), .illegal_op(b_illegal), .state_o(b_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and land 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One comparison point: prints one line per vector.
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("vec %0d %s observed=%0d expected=%0d", vectors, tag, obs, exp);
  endtask

  logic [5:0] br_op  [4];
  logic       br_zero[4];
  logic       br_exp [4];

  initial begin
    vectors = 0;
    miscompares = 0;
    br_op[0] = 6'b000100; br_zero[0] = 1'b1; br_exp[0] = 1'b1;
    br_op[1] = 6'b000100; br_zero[1] = 1'b0; br_exp[1] = 1'b0;
    br_op[2] = 6'b000101; br_zero[2] = 1'b1; br_exp[2] = 1'b0;
    br_op[3] = 6'b000101; br_zero[3] = 1'b0; br_exp[3] = 1'b1;

    // ---- Test 1: reset, then lw with no wait states ----
    reset_a = 1'b1; op_a = 6'b100011; zero_a = 1'b0; mem_ready_a = 1'b1;
    reset_b = 1'b1; op_b = 6'b000000; zero_b = 1'b0; mem_ready_b = 1'b0;
    tick(); tick();
    #1;
    chk("rst_state", a_state, 4'd0);
    chk("rst_irwrite", {3'b0, a_irwrite}, 4'd0);
    chk("rst_pcwrite", {3'b0, a_pcwrite}, 4'd0);
    chk("rst_regwrite", {3'b0, a_regwrite}, 4'd0);
    chk("rst_memwrite", {3'b0, a_memwrite}, 4'd0);
    chk("rst_illegal", {3'b0, a_illegal}, 4'd0);
    reset_a = 1'b0;
    #1;
    chk("lw_fetch_state", a_state, 4'd0);
    chk("lw_fetch_irwrite", {3'b0, a_irwrite}, 4'd1);
    chk("lw_fetch_pcwrite", {3'b0, a_pcwrite}, 4'd1);
    chk("lw_fetch_alusrcb", {2'b0, a_alusrcb}, 4'd1);
    tick();
    chk("lw_decode_state", a_state, 4'd1);
    chk("lw_decode_alusrcb", {2'b0, a_alusrcb}, 4'd3);
    tick();
    chk("lw_memadr_state", a_state, 4'd2);
    chk("lw_memadr_alusrca", {3'b0, a_alusrca}, 4'd1);
    chk("lw_memadr_alusrcb", {2'b0, a_alusrcb}, 4'd2);
    tick();
    chk("lw_memrd_state", a_state, 4'd3);
    chk("lw_memrd_iord", {3'b0, a_iord}, 4'd1);
    chk("lw_memrd_regwrite", {3'b0, a_regwrite}, 4'd0);
    tick();
    chk("lw_memwb_state", a_state, 4'd4);
    chk("lw_memwb_regwrite", {3'b0, a_regwrite}, 4'd1);
    chk("lw_memwb_memtoreg", {3'b0, a_memtoreg}, 4'd1);
    tick();
    chk("lw_done_state", a_state, 4'd0);
    chk("lw_done_regwrite", {3'b0, a_regwrite}, 4'd0);
    chk("lw_done_memtoreg", {3'b0, a_memtoreg}, 4'd0);

    // ---- Test 2: sw with 3 wait cycles in MEMWR ----
    op_a = 6'b101011;
    tick(); tick(); tick();
    mem_ready_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready_a = 1'b1;
      #1;
      chk("sw_memwr_state", a_state, 4'd5);
      chk("sw_memwr_memwrite", {3'b0, a_memwrite}, 4'd1);
      tick();
    end
    chk("sw_done_state", a_state, 4'd0);
    chk("sw_done_memwrite", {3'b0, a_memwrite}, 4'd0);

    // ---- Test 3: beq/bne with both zero values ----
    for (int i = 0; i < 4; i++) begin
      op_a = br_op[i];
      zero_a = br_zero[i];
      tick(); tick();
      chk("br_state", a_state, 4'd8);
      chk("br_pcwrite", {3'b0, a_pcwrite}, {3'b0, br_exp[i]});
      chk("br_pcsrc", {2'b0, a_pcsrc}, 4'd1);
      chk("br_aluop", {2'b0, a_aluop}, 4'd1);
      tick();
      chk("br_done_state", a_state, 4'd0);
    end

    // ---- Test 4: ori enabled, then an illegal opcode ----
    op_a = 6'b001101;
    tick(); tick();
    chk("ori_ex_state", a_state, 4'd12);
    chk("ori_ex_aluop", {2'b0, a_aluop}, 4'd3);
    chk("ori_ex_zeroext", {3'b0, a_zeroext}, 4'd1);
    chk("ori_ex_alusrcb", {2'b0, a_alusrcb}, 4'd2);
    tick();
    chk("ori_wb_state", a_state, 4'd10);
    chk("ori_wb_regwrite", {3'b0, a_regwrite}, 4'd1);
    chk("ori_wb_regdst", {3'b0, a_regdst}, 4'd0);
    tick();
    chk("ori_done_state", a_state, 4'd0);
    op_a = 6'b111111;
    tick();
    chk("ill_decode_state", a_state, 4'd1);
    chk("ill_decode_flag", {3'b0, a_illegal}, 4'd1);
    tick();
    chk("ill_next_state", a_state, 4'd0);
    chk("ill_next_flag", {3'b0, a_illegal}, 4'd0);

    // ---- Test 5: fetch stalls for 2 cycles ----
    op_a = 6'b101011;
    mem_ready_a = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("stall_state", a_state, 4'd0);
      chk("stall_irwrite", {3'b0, a_irwrite}, 4'd0);
      chk("stall_pcwrite", {3'b0, a_pcwrite}, 4'd0);
      tick();
    end
    mem_ready_a = 1'b1;
    #1;
    chk("stall_rel_irwrite", {3'b0, a_irwrite}, 4'd1);
    chk("stall_rel_pcwrite", {3'b0, a_pcwrite}, 4'd1);
    tick();
    chk("stall_rel_state", a_state, 4'd1);

    // ---- Test 6: reset during MEMWR, then an R-type ----
    tick(); tick();
    mem_ready_a = 1'b0;
    #1;
    chk("rw_memwr_state", a_state, 4'd5);
    chk("rw_memwr_memwrite", {3'b0, a_memwrite}, 4'd1);
    reset_a = 1'b1;
    #1;
    chk("rw_rst_memwrite", {3'b0, a_memwrite}, 4'd0);
    tick();
    chk("rw_rst_state", a_state, 4'd0);
    chk("rw_rst_memwrite2", {3'b0, a_memwrite}, 4'd0);
    reset_a = 1'b0;
    op_a = 6'b000000;
    mem_ready_a = 1'b1;
    tick();
    chk("r_decode_state", a_state, 4'd1);
    tick();
    chk("r_exec_state", a_state, 4'd6);
    chk("r_exec_aluop", {2'b0, a_aluop}, 4'd2);
    chk("r_exec_alusrca", {3'b0, a_alusrca}, 4'd1);
    chk("r_exec_alusrcb", {2'b0, a_alusrcb}, 4'd0);
    tick();
    chk("r_wb_state", a_state, 4'd7);
    chk("r_wb_regdst", {3'b0, a_regdst}, 4'd1);
    chk("r_wb_regwrite", {3'b0, a_regwrite}, 4'd1);
    tick();
    chk("r_done_state", a_state, 4'd0);

    // ---- Options disabled: bne/ori illegal, no handshake ----
    reset_b = 1'b0;
    op_b = 6'b000101;
    mem_ready_b = 1'b0;
    #1;
    chk("b_fetch_state", b_state, 4'd0);
    chk("b_fetch_irwrite", {3'b0, b_irwrite}, 4'd1);
    chk("b_fetch_pcwrite", {3'b0, b_pcwrite}, 4'd1);
    tick();
    chk("b_bne_state", b_state, 4'd1);
    chk("b_bne_illegal", {3'b0, b_illegal}, 4'd1);
    tick();
    chk("b_bne_next_state", b_state, 4'd0);
    chk("b_bne_next_illegal", {3'b0, b_illegal}, 4'd0);
    op_b = 6'b001101;
    tick();
    chk("b_ori_illegal", {3'b0, b_illegal}, 4'd1);
    tick();
    chk("b_ori_next_state", b_state, 4'd0);
    chk("b_ori_next_illegal", {3'b0, b_illegal}, 4'd0);
    chk("b_ori_regwrite", {3'b0, b_regwrite}, 4'd0);
    tick();
    chk("b_ori_again_state", b_state, 4'd1);
    chk("b_ori_again_regwrite", {3'b0, b_regwrite}, 4'd0);
    tick();
    op_b = 6'b101011;
    tick(); tick(); tick();
    chk("b_sw_memwr_state", b_state, 4'd5);
    chk("b_sw_memwrite", {3'b0, b_memwrite}, 4'd1);
    tick();
    chk("b_sw_done_state", b_state, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multicycle MIPS main controller, the sequential successor to the single-cycle main decoder. A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback. It drives datapath mux selects and write strobes, and stalls on a memory ready handshake. Optional ops (bne, ori) are enabled by parameter. It sits between the instruction register opcode field and the shared multicycle datapath; the ALU decoder consumes its aluop.

Parameters:
SUPPORT_BNE, 1, decode opcode 000101 as branch-not-equal; 0 makes it illegal
SUPPORT_ORI, 1, decode opcode 001101 as ori (zero-extended immediate OR); 0 makes it illegal
MEM_HANDSHAKE, 1, honour mem_ready; 0 treats mem_ready as constant 1

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
op  in  6  opcode from instruction register, stable from DECODE until next FETCH
zero  in  1  ALU zero flag
mem_ready  in  1  memory completed access this cycle
pcwrite  out  1  PC enable (unconditional or branch-qualified)
iord  out  1  memory address select: 0 PC, 1 ALUOut
irwrite  out  1  instruction register write
memwrite  out  1  memory write strobe
regdst  out  1  dest reg: 0 rt, 1 rd
memtoreg  out  1  writeback data: 0 ALUOut, 1 Data
regwrite  out  1  register file write
alusrca  out  1  ALU A: 0 PC, 1 rs
alusrcb  out  2  ALU B: 00 rt, 01 const 4, 10 immediate, 11 immediate<<2
zeroext  out  1  immediate zero-extended when 1, sign-extended when 0
pcsrc  out  2  next PC: 00 ALU result, 01 ALUOut, 10 jump target
aluop  out  2  00 add, 01 sub, 10 use funct, 11 or
illegal_op  out  1  unsupported opcode seen in DECODE
state_o  out  4  current state, for debug and verification

Behaviour:
- Synchronous reset: the next rising edge sets state = FETCH. While reset is high, pcwrite, irwrite, memwrite and regwrite are forced 0 and illegal_op is 0, regardless of state. Reset mid-instruction abandons it with no partial write.
- Outputs are pure functions of state (plus zero/op in BRANCH and mem_ready in FETCH and MEMWR). Unlisted outputs default to 0.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, IMMWB 10, JUMP 11, ORIEX 12. Codes 13-15 go to FETCH.
- FETCH: iord 0, alusrcb 01, aluop 00, pcsrc 00. irwrite = pcwrite = mem_ready. Go to DECODE on mem_ready, else hold.
- DECODE: alusrcb 11, aluop 00. Next state by opcode:
  - 100011/101011 -> MEMADR
  - 000000 -> EXECUTE
  - 000100 -> BRANCH; 000101 -> BRANCH (if SUPPORT_BNE)
  - 001000 -> ADDIEX; 001101 -> ORIEX (if SUPPORT_ORI)
  - 000010 -> JUMP
  - otherwise illegal_op = 1 for this cycle and -> FETCH (executes as nop; PC already advanced).
- MEMADR: alusrca 1, alusrcb 10, aluop 00. -> MEMRD for lw, MEMWR for sw.
- MEMRD: iord 1. Hold until mem_ready, then -> MEMWB.
- MEMWB: regdst 0, memtoreg 1, regwrite 1. -> FETCH.
- MEMWR: iord 1, memwrite 1, held every cycle until mem_ready. -> FETCH on mem_ready.
- EXECUTE: alusrca 1, alusrcb 00, aluop 10. -> ALUWB.
- ALUWB: regdst 1, regwrite 1. -> FETCH.
- BRANCH: alusrca 1, alusrcb 00, aluop 01, pcsrc 01. pcwrite = zero for beq, ~zero for bne. -> FETCH.
- ADDIEX: alusrca 1, alusrcb 10, aluop 00. ORIEX: same selects, aluop 11, zeroext 1. Both -> IMMWB.
- IMMWB: regdst 0, memtoreg 0, regwrite 1. -> FETCH.
- JUMP: pcsrc 10, pcwrite 1. -> FETCH.
- Cycle counts with no wait states: lw 5, sw/R/addi/ori 4, beq/bne/j 3. Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state enum (4-bit, encoding above)
  - opcode localparams OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_J
  - aluop constants ALU_ADD, ALU_SUB, ALU_FUNCT, ALU_OR
- One sub-module, mips_ctrl_outdec: combinational state-to-control-word decoder. The top holds the state register, next-state logic, handshake gating and reset gating.

Test Plan:
1. Reset 2 cycles, op=100011, mem_ready=1 -> state_o 0,1,2,3,4,0. regwrite=1 and memtoreg=1 only in state 4. No writes during reset.
2. op=101011, mem_ready low for 3 cycles in MEMWR -> state_o holds 5 and memwrite=1 for 4 cycles, then FETCH. memwrite=0 afterwards.
3. op=000100: zero=1 -> pcwrite=1, pcsrc=01 in state 8; zero=0 -> pcwrite=0. op=000101 gives the inverse. With SUPPORT_BNE=0, op=000101 -> illegal_op=1 in DECODE, no pcwrite in BRANCH.
4. op=001101, SUPPORT_ORI=1 -> state 12 with aluop=11, zeroext=1, then state 10 with regwrite=1. SUPPORT_ORI=0 -> illegal_op=1 for 1 cycle, back to 0, no regwrite.
5. mem_ready=0 for 2 cycles in FETCH -> irwrite=pcwrite=0 and state 0 held; both are 1 on the cycle mem_ready=1. With MEM_HANDSHAKE=0, fetch takes 1 cycle with mem_ready tied 0.
6. Reset asserted while in MEMWR with memwrite=1 -> memwrite=0 that cycle, state_o=0 after the edge. op=000000 then runs 4 cycles ending with regdst=1, regwrite=1.
